// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the iterative AES-128 inverse cipher core:
//   NR / NR_IDX      number of rounds (AES-128 only)
//   fsm_t            controller states
//   gf_xtime/gf_mul  GF(2^8) arithmetic, reduction polynomial 0x11B
//   byte_lsb         (row, col) -> bit offset of that byte in a 128-bit block
//   inv_shift_rows   InvShiftRows on a whole block
//   inv_mix_columns  InvMixColumns on a whole block
// Block byte order: byte k = 4*col + row is the k-th byte counted from the MSB,
// so a FIPS-197 hex string maps directly onto a 128-bit literal.
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam int          NR     = 10;
  localparam logic [3:0]  NR_IDX = 4'(NR);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } fsm_t;

  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply; with a constant operand this folds to a few XORs.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = gf_xtime(p);
    end
    return acc;
  endfunction

  function automatic int unsigned byte_lsb(input int unsigned row, input int unsigned col);
    return 32'd120 - 32'd8 * (32'd4 * col + row);
  endfunction

  // out[r][c] = in[r][(c - r) mod 4]: row r rotates right by r positions.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        o[byte_lsb(r, c) +: 8] = s[byte_lsb(r, (c + 4 - r) % 4) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[byte_lsb(0, c) +: 8];
      a1 = s[byte_lsb(1, c) +: 8];
      a2 = s[byte_lsb(2, c) +: 8];
      a3 = s[byte_lsb(3, c) +: 8];
      o[byte_lsb(0, c) +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[byte_lsb(1, c) +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[byte_lsb(2, c) +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[byte_lsb(3, c) +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// -----------------------------------------------------------------------------
// inv_sbox
// Combinational AES inverse S-box.
//   in_byte   in  8  byte to substitute
//   out_byte  out 8  InvSubBytes(in_byte)
// -----------------------------------------------------------------------------
module inv_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign out_byte = INV_SBOX[in_byte];

endmodule

// File: rtl/aes_inv_cipher_core.sv
// -----------------------------------------------------------------------------
// aes_inv_cipher_core
// Iterative AES-128 decryption: one inverse round per clock, 13-cycle block
// throughput. Round keys come combinationally from an external key store.
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid/ready  ciphertext handshake, in_data = ciphertext block
//   key_idx         round-key index requested this cycle (decode of state only)
//   round_key       round key key_idx, sampled at the edge closing the cycle
//   out_valid/ready plaintext handshake, out_data = plaintext block
//   busy            high whenever the controller is not IDLE
// Schedule: IDLE -accept-> INIT (key 10) -> 9x ROUND (keys 9..1) -> FINAL (key 0)
//           -> DONE (hold result until out_ready) -> IDLE.
// -----------------------------------------------------------------------------
module aes_inv_cipher_core
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   key_idx,
  input  logic [127:0] round_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state;
  logic [3:0]   rnd;

  logic [127:0] isr;        // InvShiftRows(state)
  logic [127:0] isb;        // InvSubBytes(InvShiftRows(state))
  logic [127:0] final_out;  // ... ^ round_key
  logic [127:0] mix_out;    // InvMixColumns of the above

  assign isr = inv_shift_rows(state);

  // S-box is byte-local, so slicing the raw bit vector is order-agnostic.
  for (genvar k = 0; k < 16; k++) begin : g_sbox
    inv_sbox u_inv_sbox (
      .in_byte  (isr[8*k +: 8]),
      .out_byte (isb[8*k +: 8])
    );
  end

  assign final_out = isb ^ round_key;
  assign mix_out   = inv_mix_columns(final_out);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_q <= ST_IDLE;
    else        fsm_q <= fsm_d;
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE:  if (in_valid) fsm_d = ST_INIT;
      ST_INIT:  fsm_d = ST_ROUND;
      ST_ROUND: if (rnd == 4'd1) fsm_d = ST_FINAL;
      ST_FINAL: fsm_d = ST_DONE;
      ST_DONE:  if (out_ready) fsm_d = ST_IDLE;
      default:  fsm_d = ST_IDLE;
    endcase
  end

  // Outputs decode the registered state only: no in_valid->in_ready or
  // out_ready->out_valid combinational path.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    key_idx   = '0;
    case (fsm_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_INIT:  key_idx = NR_IDX;
      ST_ROUND: key_idx = rnd;
      ST_DONE:  out_valid = 1'b1;
      default:  ;
    endcase
  end

  assign out_data = out_valid ? state : '0;

  // Datapath: one transformation per state; state is held in DONE/IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
      rnd   <= '0;
    end else begin
      case (fsm_q)
        ST_IDLE:  if (in_valid) state <= in_data;
        ST_INIT: begin
          state <= state ^ round_key;
          rnd   <= NR_IDX - 4'd1;
        end
        ST_ROUND: begin
          state <= mix_out;
          rnd   <= rnd - 4'd1;
        end
        ST_FINAL: state <= final_out;
        default:  ;
      endcase
    end
  end

endmodule
